// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: redirect codes,
// FSM states, the bubble instruction and the IF/ID record layout.
package fetch_stage_pkg;

   // jorbranch encodings from the control unit
   localparam logic [1:0] JB_PC4    = 2'b00;
   localparam logic [1:0] JB_BRANCH = 2'b01;
   localparam logic [1:0] JB_JALR   = 2'b10;
   localparam logic [1:0] JB_RSVD   = 2'b11;

   // addi x0,x0,0 injected on bubbles
   localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] ir;
      logic [31:0] pc;
      logic [31:0] pc4;
   } ifid_t;

   // Reserved code 11 behaves like sequential fetch.
   function automatic logic is_redirect(input logic [1:0] jb);
      return (jb == JB_BRANCH) || (jb == JB_JALR);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and a 1-cycle-latency synchronous instruction memory (slave).
interface fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic [31:0] rdata;

   modport master (output req, output addr, input rdata);
   modport slave  (input req, input addr, output rdata);
endinterface

// File: rtl/fetch_stage_skid.sv
// fetch_skid: one-entry {ir,pc} holding buffer that catches the response
// arriving while decode is stalled. Clear has priority over load.
module fetch_skid (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        load,
   input  logic [31:0] in_ir,
   input  logic [31:0] in_pc,
   output logic        valid,
   output logic [31:0] ir,
   output logic [31:0] pc
);

   logic        valid_q, valid_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc_q, pc_d;

   // Next-entry selection: clear beats load, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         ir_d    = in_ir;
         pc_d    = in_pc;
      end
   end

   // Entry registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ir_q    <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
      end
   end

   assign valid = valid_q;
   assign ir    = ir_q;
   assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch plus IF/ID pipeline register.
// Sequential fetch from a 1-cycle synchronous imem, redirect on branch/jalr
// with a 2-bubble penalty, and a one-entry skid to absorb decode stalls.
// Optional: define FETCH_MISALIGN_TRAP_EN to vector targets with bit1 set
// to TRAP_PC and raise the one-cycle fetch_misalign output.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = FETCH_NOP,
   parameter logic [31:0] TRAP_PC   = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [1:0]  jorbranch,
   input  logic [31:0] branch_target,
   input  logic [31:0] jalr_target,
   fetch_stage_if.master imem,
   output logic        ifid_valid,
   output logic [31:0] ifid_ir,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        fetch_misalign
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  rsp_pc_q, rsp_pc_d;
   logic         inflight_q, inflight_d;
   logic         kill_q, kill_d;
   ifid_t        ifid_q, ifid_d;

   logic         redirect;
   logic         rsp_accept;
   logic         req;
   logic [31:0]  raw_target;
   logic [31:0]  target;
   logic         skid_load, skid_clear, skid_valid;
   logic [31:0]  skid_ir, skid_pc;

   assign redirect   = is_redirect(jorbranch);
   assign raw_target = (jorbranch == JB_JALR) ? jalr_target : branch_target;
   // A response is present whenever a request went out last cycle.
   assign rsp_accept = inflight_q && !kill_q;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign target = raw_target[1] ? TRAP_PC : (raw_target & 32'hFFFF_FFFE);
`else
   assign target = raw_target & 32'hFFFF_FFFC;
`endif

   // Next-state: redirect flushes everything, otherwise the FSM decides
   // whether to issue, fill IF/ID, park a response in the skid, or drain it.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = 1'b0;
      kill_d     = 1'b0;
      ifid_d     = ifid_q;
      req        = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (redirect) begin
         pc_d       = target;
         kill_d     = inflight_q;
         skid_clear = 1'b1;
         state_d    = FETCH_RUN;
         ifid_d     = '{valid: 1'b0, ir: NOP_INSTR, pc: ifid_q.pc, pc4: ifid_q.pc4};
      end else begin
         case (state_q)
            FETCH_IDLE: state_d = FETCH_RUN;
            FETCH_RUN: begin
               if (rsp_accept && stall) begin
                  // Decode cannot take it: park it and stop fetching.
                  skid_load = 1'b1;
                  state_d   = FETCH_HOLD;
               end else begin
                  req = 1'b1;
                  if (!stall) begin
                     if (rsp_accept)
                        ifid_d = '{valid: 1'b1, ir: imem.rdata, pc: rsp_pc_q,
                                   pc4: rsp_pc_q + 32'd4};
                     else
                        ifid_d = '{valid: 1'b0, ir: NOP_INSTR, pc: ifid_q.pc,
                                   pc4: ifid_q.pc4};
                  end
               end
            end
            FETCH_HOLD: begin
               if (!stall) begin
                  if (skid_valid)
                     ifid_d = '{valid: 1'b1, ir: skid_ir, pc: skid_pc,
                                pc4: skid_pc + 32'd4};
                  else
                     ifid_d = '{valid: 1'b0, ir: NOP_INSTR, pc: ifid_q.pc,
                                pc4: ifid_q.pc4};
                  skid_clear = 1'b1;
                  state_d    = FETCH_RUN;
                  req        = 1'b1;
               end
            end
            default: state_d = FETCH_IDLE;
         endcase
      end
      if (req) begin
         pc_d       = pc_q + 32'd4;
         rsp_pc_d   = pc_q;
         inflight_d = 1'b1;
      end
   end

   // Pipeline state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FETCH_IDLE;
         pc_q       <= RESET_PC;
         rsp_pc_q   <= '0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
         ifid_q     <= '{valid: 1'b0, ir: NOP_INSTR, pc: 32'd0, pc4: 32'd0};
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
         ifid_q     <= ifid_d;
      end
   end

   fetch_skid u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (skid_clear),
      .load  (skid_load),
      .in_ir (imem.rdata),
      .in_pc (rsp_pc_q),
      .valid (skid_valid),
      .ir    (skid_ir),
      .pc    (skid_pc)
   );

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   // Flag is high for the cycle right after a redirect to a bit1-set target.
   always_comb begin
      misalign_d = redirect && raw_target[1];
   end

   // Misalign flag register.
   always_ff @(posedge clk) begin
      if (!rst_n) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end

   assign fetch_misalign = misalign_q;
`endif

   assign imem.req   = req;
   assign imem.addr  = pc_q;
   assign ifid_valid = ifid_q.valid;
   assign ifid_ir    = ifid_q.ir;
   assign ifid_pc    = ifid_q.pc;
   assign ifid_pc4   = ifid_q.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized stall and
// redirect traffic. A monitor checks every instruction decode consumes
// against the expected program-order PC stream.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [1:0]  jorbranch;
   logic [31:0] branch_target;
   logic [31:0] jalr_target;
   logic        ifid_valid;
   logic [31:0] ifid_ir, ifid_pc, ifid_pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misalign;
`endif

   fetch_stage_if imem_bus ();

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP), .TRAP_PC(TRAP_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .jorbranch     (jorbranch),
      .branch_target (branch_target),
      .jalr_target   (jalr_target),
      .imem          (imem_bus),
      .ifid_valid    (ifid_valid),
      .ifid_ir       (ifid_ir),
      .ifid_pc       (ifid_pc),
      .ifid_pc4      (ifid_pc4)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misalign(fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int delivered = 0;
   logic [31:0] tgt_q[$];
   logic [31:0] exp_pc = RESET_PC;
   logic        prev_mis = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (t[1]) return TRAP_PC;
      return t & 32'hFFFF_FFFE;
`else
      return t & 32'hFFFF_FFFC;
`endif
   endfunction

   function automatic logic exp_misalign(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
      return t[1];
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, act, exp);
      end
   endtask

   // Synchronous instruction memory: one-cycle read latency, garbage when idle.
   always @(posedge clk) begin
      imem_bus.rdata <= imem_bus.req ? mem_word(imem_bus.addr) : 32'hDEAD_BEEF;
   end

   // Monitor: every instruction decode consumes must be the next one in
   // program order; a redirect resets the expected stream to its target.
   always @(negedge clk) begin
      logic [31:0] raw_t;
      if (!rst_n) begin
         exp_pc   = RESET_PC;
         prev_mis = 1'b0;
         tgt_q.delete();
      end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
         check("misalign_pulse", {31'd0, fetch_misalign}, {31'd0, prev_mis});
`endif
         if (ifid_valid && !stall) begin
            check("sb_pc", ifid_pc, exp_pc);
            check("sb_ir", ifid_ir, mem_word(exp_pc));
            check("sb_pc4", ifid_pc4, exp_pc + 32'd4);
            $display("consume pc=%h ir=%h", ifid_pc, ifid_ir);
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         raw_t = (jorbranch == 2'b10) ? jalr_target : branch_target;
         prev_mis = 1'b0;
         if (jorbranch == 2'b01 || jorbranch == 2'b10) begin
            prev_mis = exp_misalign(raw_t);
            if (tgt_q.size() == 0) check("sb_redirect_queue", 32'd0, 32'd1);
            else exp_pc = tgt_q.pop_front();
         end
         if (imem_bus.req) check("addr_align", imem_bus.addr & 32'd3, 32'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic redirect(input logic [1:0] jb, input logic [31:0] t);
      jorbranch = jb;
      if (jb == 2'b10) begin
         jalr_target   = t;
         branch_target = $urandom;
      end else begin
         branch_target = t;
         jalr_target   = $urandom;
      end
      tgt_q.push_back(eff_target(t));
   endtask

   task automatic wait_addr(input logic [31:0] a);
      for (int i = 0; i < 200; i++) begin
         step();
         sample();
         if (imem_bus.req && imem_bus.addr == a) return;
      end
      check("wait_addr_timeout", 32'd0, a);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; jorbranch = 2'b00;
      branch_target = '0; jalr_target = '0;
      step(); step();
      sample();
      check("rst_valid", {31'd0, ifid_valid}, 32'd0);
      check("rst_ir", ifid_ir, NOP);
      check("rst_pc", ifid_pc, 32'd0);
      check("rst_pc4", ifid_pc4, 32'd0);
      check("rst_req", {31'd0, imem_bus.req}, 32'd0);

      // Free run from reset
      step(); rst_n = 1'b1; sample();
      check("idle_req", {31'd0, imem_bus.req}, 32'd0);
      step(); sample();
      check("run_req0", {31'd0, imem_bus.req}, 32'd1);
      check("run_addr0", imem_bus.addr, 32'h0);
      step(); sample();
      check("run_addr4", imem_bus.addr, 32'h4);
      step(); sample();
      check("run_addr8", imem_bus.addr, 32'h8);
      check("first_valid", {31'd0, ifid_valid}, 32'd1);
      check("first_pc", ifid_pc, 32'h0);

      // Stall for 3 cycles while 0x10 is returning
      wait_addr(32'h10);
      step(); stall = 1'b1; sample();
      check("stall_req1", {31'd0, imem_bus.req}, 32'd0);
      check("stall_pc_held", ifid_pc, 32'hC);
      step(); sample();
      check("hold_req2", {31'd0, imem_bus.req}, 32'd0);
      check("hold_ir", ifid_ir, mem_word(32'hC));
      step(); sample();
      check("hold_req3", {31'd0, imem_bus.req}, 32'd0);
      step(); stall = 1'b0; sample();
      check("exit_req", {31'd0, imem_bus.req}, 32'd1);
      check("exit_addr", imem_bus.addr, 32'h14);
      step(); sample();
      check("skid_pc", ifid_pc, 32'h10);
      check("skid_ir", ifid_ir, mem_word(32'h10));
      check("skid_valid", {31'd0, ifid_valid}, 32'd1);

      // Branch while 0x40 in flight
      wait_addr(32'h40);
      step(); redirect(2'b01, 32'h200); sample();
      check("br_cur_pc", ifid_pc, 32'h3C);
      step(); jorbranch = 2'b00; sample();
      check("br_bubble1_v", {31'd0, ifid_valid}, 32'd0);
      check("br_bubble1_ir", ifid_ir, NOP);
      check("br_req_addr", imem_bus.addr, 32'h200);
      step(); sample();
      check("br_bubble2_v", {31'd0, ifid_valid}, 32'd0);
      check("br_bubble2_ir", ifid_ir, NOP);
      step(); sample();
      check("br_tgt_v", {31'd0, ifid_valid}, 32'd1);
      check("br_tgt_pc", ifid_pc, 32'h200);
      check("br_tgt_pc4", ifid_pc4, 32'h204);

      // JALR targets: low bits handling
      step(); redirect(2'b10, 32'h305); sample();
      step(); jorbranch = 2'b00; sample();
      check("jalr_305_addr", imem_bus.addr, 32'h304);
      step(); redirect(2'b10, 32'h306); sample();
      step(); jorbranch = 2'b00; sample();
      check("jalr_306_addr", imem_bus.addr, eff_target(32'h306));
      step(); sample();
      repeat (4) step();

      // Redirect with stall while the skid is full
      step(); stall = 1'b1; sample();
      check("s5_enter_hold", {31'd0, imem_bus.req}, 32'd0);
      step(); redirect(2'b01, 32'h480); sample();
      check("s5_hold_req", {31'd0, imem_bus.req}, 32'd0);
      step(); jorbranch = 2'b00; stall = 1'b0; sample();
      check("s5_tgt_addr", imem_bus.addr, 32'h480);
      check("s5_flush_v", {31'd0, ifid_valid}, 32'd0);
      step(); step(); sample();
      check("s5_tgt_pc", ifid_pc, 32'h480);
      repeat (3) step();

      // Reset in the middle of HOLD
      step(); stall = 1'b1;
      step(); rst_n = 1'b0; sample();
      check("h6_hold_req", {31'd0, imem_bus.req}, 32'd0);
      step(); rst_n = 1'b1; stall = 1'b0; sample();
      check("h6_rst_valid", {31'd0, ifid_valid}, 32'd0);
      check("h6_rst_ir", ifid_ir, NOP);
      check("h6_rst_pc", ifid_pc, 32'd0);
      check("h6_rst_req", {31'd0, imem_bus.req}, 32'd0);
      step(); sample();
      check("h6_restart_addr", imem_bus.addr, RESET_PC);

      // Wrap-around at the top of the address space
      repeat (3) step();
      step(); redirect(2'b01, 32'hFFFF_FFF8); sample();
      step(); jorbranch = 2'b00;
      wait_addr(32'h0000_0004);

      // Randomized stall / redirect traffic
      for (int n = 0; n < 400; n++) begin
         int r;
         logic [31:0] t;
         step();
         stall = ($urandom_range(0, 99) < 30);
         r = $urandom_range(0, 99);
         t = (r == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFF);
         if (r < 6)       redirect(2'b01, t);
         else if (r < 10) redirect(2'b10, t);
         else begin
            jorbranch     = (r < 13) ? 2'b11 : 2'b00;
            branch_target = $urandom;
            jalr_target   = $urandom;
         end
      end
      step(); jorbranch = 2'b00; stall = 1'b0;
      repeat (10) step();
      check("progress", (delivered > 150) ? 32'd1 : 32'd0, 32'd1);
      check("queue_drained", tgt_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core.
- Issues sequential fetch requests to a 1-cycle-latency synchronous instruction memory.
- Consumes the control unit's jorbranch redirect decision, absorbs hazard stalls with a one-entry skid buffer, and presents IR/PC to the decode stage, where the control unit reads IR.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction injected on bubbles (addi x0,x0,0).
- TRAP_PC, 32'h0000_0100, misaligned-target vector (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  decode-stage hazard hold; IF/ID must not change
- jorbranch  in  2  from control unit: 00 pc+4, 01 branch, 10 jalr, 11 reserved (treated as 00)
- branch_target  in  32  PC-relative target, valid when jorbranch=01
- jalr_target  in  32  rs1+imm target, valid when jorbranch=10
- imem_req  out  1  read request this cycle
- imem_addr  out  32  word-aligned request address
- imem_rdata  in  32  data for the request issued in the previous cycle
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_ir  out  32  instruction to decode/control unit
- ifid_pc  out  32  PC of ifid_ir
- ifid_pc4  out  32  ifid_pc+4, used for JAL/JALR link value

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset values (rst_n=0 at a clk edge):
  - state=IDLE, pc_q=RESET_PC, inflight=0, kill=0, skid_valid=0.
  - ifid_valid=0, ifid_ir=NOP_INSTR, ifid_pc=0, ifid_pc4=0.
  - imem_req=0.
- FSM states:
  - IDLE: first cycle after reset release. No request issued. Transitions to RUN.
  - RUN: imem_req=1, imem_addr=pc_q. Each issued request sets pc_q+=4 and inflight=1, and records rsp_pc=pc_q.
  - HOLD: skid full and stall high. imem_req=0; pc_q frozen.
- Response handling (inflight=1):
  - Response is imem_rdata in the cycle after issue.
  - If kill=1: response discarded.
  - Else if stall=0: IF/ID loads {1, rdata, rsp_pc, rsp_pc+4}.
  - Else: response goes to the skid, skid_valid=1, state moves to HOLD, and no request is issued that cycle.
- HOLD exit: when stall falls, IF/ID loads the skid, skid_valid=0, state moves to RUN, and the request for pc_q is issued in the same cycle.
- Stall with empty skid: IF/ID holds. A request was already issued last cycle, so it lands in the skid next cycle.
- Redirect (jorbranch=01 or 10), evaluated every cycle:
  - Priority is reset > redirect > stall.
  - Target is branch_target or jalr_target with bit0 cleared; bit1 is cleared when the optional feature is absent.
  - At the edge: pc_q=target, kill=inflight, skid_valid=0, state=RUN.
  - IF/ID flushed to {0, NOP_INSTR, ifid_pc, ifid_pc4}.
  - No request is issued in the redirect cycle. First target request goes out the next cycle, giving a 2-bubble branch penalty.
- No response may be dropped or duplicated except through kill or flush.
- pc_q wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Reset asserted mid-stall or mid-redirect overrides everything. An in-flight response arriving after reset is ignored because inflight=0.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect target with bit1=1 sends pc_q to TRAP_PC instead of the target.
  - fetch_misalign pulses high for exactly the redirect cycle+1.
  - Flush is otherwise identical.
- Undefined: port absent; target bits[1:0] forced to 00.

Decomposition:
- defines.v additions:
  - JB_PC4/JB_BRANCH/JB_JALR/JB_RSVD encodings (2'b00..2'b11).
  - FETCH_IDLE/FETCH_RUN/FETCH_HOLD state encodings.
  - NOP_INSTR constant.
- One sub-module: fetch_skid, a one-entry {ir,pc} buffer with load, clear, valid, and data ports.

Test Plan:
- Reset, then free-run with stall=0 and jorbranch=00 -> imem_addr 0,4,8,... from the 2nd cycle after release; ifid_pc trails imem_addr by 2 cycles; ifid_valid=1 from cycle 3.
- Stall high for 3 cycles while fetching 0x10 -> skid captures 0x10's instruction, imem_req=0 during HOLD, ifid_ir held. On release, ifid_pc=0x10 and the next request is 0x14 in the same cycle; no gap or duplicate.
- jorbranch=01, branch_target=0x200 while 0x40 is in flight -> the 0x40 response is discarded, two ifid_valid=0 bubbles with ifid_ir=0x00000013, then ifid_pc=0x200.
- jorbranch=10, jalr_target=0x305 -> fetch resumes at 0x304 (feature off). With FETCH_MISALIGN_TRAP_EN and jalr_target=0x306 -> pc=0x100 and a one-cycle fetch_misalign pulse.
- Redirect asserted together with stall while the skid is full -> skid cleared, flush wins, fetch resumes at the target.
- rst_n=0 for 1 cycle mid-HOLD -> all outputs return to reset values next edge, and fetch restarts at RESET_PC.
